// File: rtl/sha_mem_pkg.sv
// sha_mem_pkg: shared types and constants for the SHA-256 memory-side host.
// Holds the host FSM state encoding, bus widths, the hash length and the
// default message/output base addresses. It also has small state-classification
// helpers that the top level and its next-state logic both use.
package sha_mem_pkg;

  localparam int WORD_W     = 32;
  localparam int ADDR_W     = 16;
  localparam int CNT_W      = ADDR_W + 1;  // load count must reach 65536
  localparam int HASH_WORDS = 8;

  localparam logic [ADDR_W-1:0] DEF_MSG_BASE = 16'h0000;
  localparam logic [ADDR_W-1:0] DEF_OUT_BASE = 16'h0080;

  typedef enum logic [2:0] {
    ST_LOAD      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_LOW  = 3'd3,
    ST_WAIT_HIGH = 3'd4,
    ST_DRD       = 3'd5,
    ST_DOUT      = 3'd6
  } state_t;

  // Busy covers everything except collecting the message and waiting for run.
  function automatic logic is_busy(input state_t s);
    return !((s == ST_LOAD) || (s == ST_ARMED));
  endfunction

  // The engine owns the RAM port only while a hash is in flight.
  function automatic logic eng_owns_port(input state_t s);
    return (s == ST_START) || (s == ST_WAIT_LOW) || (s == ST_WAIT_HIGH);
  endfunction

endpackage

// File: rtl/sha_mem_host_if.sv
// sha_mem_host_if: bundles the host load stream, run request, hash drain
// stream, status flags and the SHA engine's memory/control port.
//   slave  : the sha_mem_host side (drives ld_ready, eng_*, hash_*, busy, err)
//   master : the host + engine side (drives ld_valid/ld_data, run, hash_ready,
//            eng_done and the engine memory requests)
interface sha_mem_host_if;
  import sha_mem_pkg::*;

  // host load stream
  logic              ld_valid;
  logic              ld_ready;
  logic [WORD_W-1:0] ld_data;
  logic              run;
  // engine control and memory port
  logic              eng_start;
  logic [ADDR_W-1:0] eng_message_addr;
  logic [ADDR_W-1:0] eng_output_addr;
  logic              eng_done;
  logic              eng_mem_we;
  logic [ADDR_W-1:0] eng_mem_addr;
  logic [WORD_W-1:0] eng_mem_write_data;
  logic [WORD_W-1:0] eng_mem_read_data;
  // hash drain stream
  logic              hash_valid;
  logic              hash_ready;
  logic [WORD_W-1:0] hash_data;
  logic              hash_last;
  // status
  logic              busy;
  logic              err;

  modport slave (
    input  ld_valid, ld_data, run, eng_done, eng_mem_we, eng_mem_addr,
           eng_mem_write_data, hash_ready,
    output ld_ready, eng_start, eng_message_addr, eng_output_addr,
           eng_mem_read_data, hash_valid, hash_data, hash_last, busy, err
  );

  modport master (
    output ld_valid, ld_data, run, eng_done, eng_mem_we, eng_mem_addr,
           eng_mem_write_data, hash_ready,
    input  ld_ready, eng_start, eng_message_addr, eng_output_addr,
           eng_mem_read_data, hash_valid, hash_data, hash_last, busy, err
  );

endinterface

// File: rtl/sha_word_ram.sv
// sha_word_ram: single-port synchronous word RAM with a registered read port.
//   clk, rst : clock, asynchronous active-high reset (read register only)
//   en       : access this cycle; we selects write, otherwise read
//   clr      : force the read register to zero (out-of-range access)
//   addr     : word address, wdata: write data
//   rdata    : read data, valid the cycle after a read; held across writes
// The storage array is deliberately not reset so contents survive reset.
module sha_word_ram
  import sha_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic              clr,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [WORD_W-1:0] rdata_r;

  // storage array write port
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_r[addr] <= wdata;
    end
  end

  // registered read data; a write leaves the last read value in place
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= {WORD_W{1'b0}};
    end else if (clr) begin
      rdata_r <= {WORD_W{1'b0}};
    end else if (en && !we) begin
      rdata_r <= mem_r[addr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/sha_mem_host.sv
// sha_mem_host: memory-side responder and host sequencer for the SHA engine.
// Loads NUM_OF_WORDS message words from the host stream into the word RAM,
// starts the engine on run, serves its RAM requests while it hashes, then
// drains the 8 hash words from OUT_BASE back to the host (h0 first).
//   clk   : single clock, shared with the engine's mem_clk
//   reset : asynchronous, active-high; RAM contents are kept
//   bus   : sha_mem_host_if.slave (load stream, run, engine port, drain
//           stream, busy and sticky err)
module sha_mem_host
  import sha_mem_pkg::*;
#(
  parameter int                DEPTH        = 256,
  parameter int                NUM_OF_WORDS = 20,
  parameter logic [ADDR_W-1:0] MSG_BASE     = DEF_MSG_BASE,
  parameter logic [ADDR_W-1:0] OUT_BASE     = DEF_OUT_BASE
) (
  input  logic          clk,
  input  logic          reset,
  sha_mem_host_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // The message must fit between MSG_BASE and the top of the RAM.
  if (NUM_OF_WORDS > (DEPTH - int'(MSG_BASE))) begin : g_cfg_check
    $error("sha_mem_host: NUM_OF_WORDS does not fit above MSG_BASE");
  end

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  ld_cnt_r, ld_cnt_nxt_s, ld_cnt_inc_s;
  logic [2:0]        k_r, k_nxt_s;
  logic              err_r, err_nxt_s;
  logic              ld_ready_r, busy_r, eng_start_r, hash_valid_r, hash_last_r;

  logic              ld_fire_s, ld_not_full_s, eng_in_range_s;
  logic [ADDR_W-1:0] ld_addr_s, drn_addr_s;

  logic              ram_en_s, ram_we_s, ram_clr_s;
  logic [AW-1:0]     ram_addr_s;
  logic [WORD_W-1:0] ram_wdata_s, ram_rdata_s;

  sha_word_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (reset),
    .en    (ram_en_s),
    .we    (ram_we_s),
    .clr   (ram_clr_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  assign ld_not_full_s  = (ld_cnt_r < CNT_W'(NUM_OF_WORDS));
  assign ld_cnt_inc_s   = ld_cnt_r + 17'd1;
  assign ld_fire_s      = (state_r == ST_LOAD) && bus.ld_valid && ld_ready_r;
  assign ld_addr_s      = MSG_BASE + ld_cnt_r[ADDR_W-1:0];
  assign drn_addr_s     = OUT_BASE + {13'd0, k_r};
  assign eng_in_range_s = ({16'd0, bus.eng_mem_addr} < 32'(DEPTH));

  // next-state, RAM port mux and error detection
  always_comb begin
    state_nxt_s  = state_r;
    ld_cnt_nxt_s = ld_cnt_r;
    k_nxt_s      = k_r;
    err_nxt_s    = err_r;
    ram_en_s     = 1'b0;
    ram_we_s     = 1'b0;
    ram_clr_s    = 1'b0;
    ram_addr_s   = {AW{1'b0}};
    ram_wdata_s  = {WORD_W{1'b0}};

    // Engine requests reach the RAM only while it is hashing; an
    // out-of-range address zeroes the read data instead of aliasing.
    if (eng_owns_port(state_r)) begin
      if (eng_in_range_s) begin
        ram_en_s    = 1'b1;
        ram_we_s    = bus.eng_mem_we;
        ram_addr_s  = AW'(bus.eng_mem_addr);
        ram_wdata_s = bus.eng_mem_write_data;
      end else begin
        ram_clr_s = 1'b1;
        err_nxt_s = 1'b1;
      end
    end else begin
      err_nxt_s = err_r | bus.eng_mem_we;
    end

    case (state_r)
      ST_LOAD: begin
        // run before the message is complete is a host protocol error
        err_nxt_s = err_nxt_s | (bus.run & ld_not_full_s);
        if (ld_fire_s) begin
          ram_en_s     = 1'b1;
          ram_we_s     = 1'b1;
          ram_addr_s   = AW'(ld_addr_s);
          ram_wdata_s  = bus.ld_data;
          ld_cnt_nxt_s = ld_cnt_inc_s;
          if (ld_cnt_inc_s == CNT_W'(NUM_OF_WORDS)) begin
            state_nxt_s = ST_ARMED;
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_ARMED: begin
        if (bus.run) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_START: begin
        // eng_done is high while idle; its fall confirms the start was seen
        if (!bus.eng_done) begin
          state_nxt_s = ST_WAIT_LOW;
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_WAIT_LOW: begin
        state_nxt_s = ST_WAIT_HIGH;
      end
      ST_WAIT_HIGH: begin
        if (bus.eng_done) begin
          state_nxt_s = ST_DRD;
        end else begin
          state_nxt_s = ST_WAIT_HIGH;
        end
      end
      ST_DRD: begin
        ram_en_s    = 1'b1;
        ram_addr_s  = AW'(drn_addr_s);
        state_nxt_s = ST_DOUT;
      end
      ST_DOUT: begin
        // hash_valid is always high here, so hash_ready alone completes it
        if (bus.hash_ready) begin
          if (k_r == 3'(HASH_WORDS - 1)) begin
            k_nxt_s      = 3'd0;
            ld_cnt_nxt_s = {CNT_W{1'b0}};
            state_nxt_s  = ST_LOAD;
          end else begin
            k_nxt_s     = k_r + 3'd1;
            state_nxt_s = ST_DRD;
          end
        end else begin
          state_nxt_s = ST_DOUT;
        end
      end
      default: begin
        state_nxt_s = ST_LOAD;
      end
    endcase
  end

  // state, counters and registered outputs (outputs follow the next state)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_LOAD;
      ld_cnt_r     <= {CNT_W{1'b0}};
      k_r          <= 3'd0;
      err_r        <= 1'b0;
      ld_ready_r   <= 1'b0;
      busy_r       <= 1'b0;
      eng_start_r  <= 1'b0;
      hash_valid_r <= 1'b0;
      hash_last_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      ld_cnt_r     <= ld_cnt_nxt_s;
      k_r          <= k_nxt_s;
      err_r        <= err_nxt_s;
      ld_ready_r   <= (state_nxt_s == ST_LOAD) &&
                      (ld_cnt_nxt_s < CNT_W'(NUM_OF_WORDS));
      busy_r       <= is_busy(state_nxt_s);
      eng_start_r  <= (state_nxt_s == ST_START);
      hash_valid_r <= (state_nxt_s == ST_DOUT);
      hash_last_r  <= (state_nxt_s == ST_DOUT) &&
                      (k_nxt_s == 3'(HASH_WORDS - 1));
    end
  end

  assign bus.ld_ready          = ld_ready_r;
  assign bus.busy              = busy_r;
  assign bus.err               = err_r;
  assign bus.eng_start         = eng_start_r;
  assign bus.eng_message_addr  = MSG_BASE;
  assign bus.eng_output_addr   = OUT_BASE;
  assign bus.eng_mem_read_data = ram_rdata_s;
  assign bus.hash_valid        = hash_valid_r;
  assign bus.hash_last         = hash_last_r;
  // the RAM read register is the capture; DOUT never touches the RAM,
  // so the word stays put until the host takes it
  assign bus.hash_data         = hash_valid_r ? ram_rdata_s : {WORD_W{1'b0}};

endmodule

// File: tb/tb_sha_mem_host.sv
// tb_sha_mem_host: directed self-checking bench for sha_mem_host. Acts as
// host and as a stub SHA engine, with hand-computed expected values.
module tb_sha_mem_host;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;
  int   got;
  int   dgot;
  logic [31:0] held;
  logic        hold_chk;

  always #5 clk = ~clk;

  sha_mem_host_if bus();

  sha_mem_host #(
    .DEPTH        (256),
    .NUM_OF_WORDS (20),
    .MSG_BASE     (16'h0000),
    .OUT_BASE     (16'h0080)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // hold ld_valid with 32'h1000_0000+k until n words are taken (bounded)
  task automatic load_words(input int n, output int taken);
    taken = 0;
    bus.ld_valid = 1'b1;
    for (int c = 0; (c < 4 * n + 8) && (taken < n); c++) begin
      bus.ld_data = 32'h1000_0000 + 32'(taken);
      if (bus.ld_ready) begin
        tick();
        taken++;
      end else begin
        tick();
      end
    end
    bus.ld_valid = 1'b0;
    bus.ld_data  = 32'h0000_0000;
  endtask

  task automatic pulse_run();
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
  endtask

  initial begin
    reset                  = 1'b1;
    bus.ld_valid           = 1'b0;
    bus.ld_data            = 32'h0000_0000;
    bus.run                = 1'b0;
    bus.eng_done           = 1'b1;
    bus.eng_mem_we         = 1'b0;
    bus.eng_mem_addr       = 16'h0000;
    bus.eng_mem_write_data = 32'h0000_0000;
    bus.hash_ready         = 1'b0;
    tick();
    tick();

    // reset values
    chk("rst_ld_ready",  {31'd0, bus.ld_ready},   32'd0);
    chk("rst_eng_start", {31'd0, bus.eng_start},  32'd0);
    chk("rst_busy",      {31'd0, bus.busy},       32'd0);
    chk("rst_err",       {31'd0, bus.err},        32'd0);
    chk("rst_hvalid",    {31'd0, bus.hash_valid}, 32'd0);
    chk("rst_hlast",     {31'd0, bus.hash_last},  32'd0);
    chk("rst_hdata",     bus.hash_data,           32'd0);
    chk("rst_rdata",     bus.eng_mem_read_data,   32'd0);
    chk("msg_addr",      {16'd0, bus.eng_message_addr}, 32'h0000_0000);
    chk("out_addr",      {16'd0, bus.eng_output_addr},  32'h0000_0080);
    reset = 1'b0;
    tick();
    chk("post_rst_ld_ready", {31'd0, bus.ld_ready}, 32'd1);

    // partial load then run: error, no start
    load_words(5, got);
    chk("part_count", 32'(got), 32'd5);
    pulse_run();
    chk("part_err",       {31'd0, bus.err},       32'd1);
    chk("part_eng_start", {31'd0, bus.eng_start}, 32'd0);
    chk("part_ld_ready",  {31'd0, bus.ld_ready},  32'd1);
    chk("part_busy",      {31'd0, bus.busy},      32'd0);
    tick();
    chk("part_eng_start2", {31'd0, bus.eng_start}, 32'd0);

    // reset clears err
    reset = 1'b1;
    #1;
    chk("rst2_err", {31'd0, bus.err}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // full load
    load_words(20, got);
    chk("load_count",    32'(got), 32'd20);
    chk("armed_ready",   {31'd0, bus.ld_ready}, 32'd0);
    chk("armed_busy",    {31'd0, bus.busy},     32'd0);
    tick();
    chk("armed_ready2",  {31'd0, bus.ld_ready}, 32'd0);

    // run; stub engine reads the message
    pulse_run();
    chk("start_eng_start", {31'd0, bus.eng_start}, 32'd1);
    chk("start_busy",      {31'd0, bus.busy},      32'd1);
    bus.eng_mem_addr = 16'h0003;
    tick();
    chk("rd_3",  bus.eng_mem_read_data, 32'h1000_0003);
    chk("start_held", {31'd0, bus.eng_start}, 32'd1);
    bus.eng_mem_addr = 16'h0013;
    tick();
    chk("rd_19", bus.eng_mem_read_data, 32'h1000_0013);
    bus.eng_done     = 1'b0;
    bus.eng_mem_addr = 16'h0000;
    tick();
    chk("start_fall", {31'd0, bus.eng_start}, 32'd0);
    chk("rd_0",       bus.eng_mem_read_data, 32'h1000_0000);
    tick();

    // stub writes the hash
    bus.eng_mem_we = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.eng_mem_addr       = 16'h0080 + 16'(i);
      bus.eng_mem_write_data = 32'h0000_00A0 + 32'(i);
      tick();
    end
    bus.eng_mem_we = 1'b0;
    chk("wr_keeps_rdata", bus.eng_mem_read_data, 32'h1000_0000);
    chk("wr_no_err",      {31'd0, bus.err}, 32'd0);
    bus.eng_mem_addr = 16'h0080;
    tick();
    chk("rd_80", bus.eng_mem_read_data, 32'h0000_00A0);

    // out-of-range write then read
    bus.eng_mem_we         = 1'b1;
    bus.eng_mem_addr       = 16'h0100;
    bus.eng_mem_write_data = 32'h0000_DEAD;
    tick();
    bus.eng_mem_we = 1'b0;
    tick();
    chk("oor_rdata", bus.eng_mem_read_data, 32'd0);
    chk("oor_err",   {31'd0, bus.err}, 32'd1);
    bus.eng_mem_addr = 16'h0000;
    tick();
    chk("oor_no_alias", bus.eng_mem_read_data, 32'h1000_0000);

    // engine finishes; drain with hash_ready toggling
    bus.eng_done = 1'b1;
    tick();
    chk("drd_busy",   {31'd0, bus.busy},       32'd1);
    chk("drd_hvalid", {31'd0, bus.hash_valid}, 32'd0);
    dgot     = 0;
    hold_chk = 1'b0;
    held     = 32'd0;
    for (int c = 0; (c < 64) && (dgot < 8); c++) begin
      bus.hash_ready = c[0];
      if (hold_chk) begin
        chk("hold_valid", {31'd0, bus.hash_valid}, 32'd1);
        chk("hold_data",  bus.hash_data, held);
      end
      hold_chk = 1'b0;
      if (bus.hash_valid && bus.hash_ready) begin
        chk("hash_data", bus.hash_data, 32'h0000_00A0 + 32'(dgot));
        chk("hash_last", {31'd0, bus.hash_last}, {31'd0, (dgot == 7)});
        dgot++;
      end else if (bus.hash_valid) begin
        held     = bus.hash_data;
        hold_chk = 1'b1;
      end
      tick();
    end
    bus.hash_ready = 1'b0;
    chk("drain_count",  32'(dgot), 32'd8);
    chk("done_ld_ready", {31'd0, bus.ld_ready},   32'd1);
    chk("done_hvalid",   {31'd0, bus.hash_valid}, 32'd0);
    chk("done_busy",     {31'd0, bus.busy},       32'd0);

    // second run, reset while waiting for the engine
    load_words(20, got);
    chk("load2_count", 32'(got), 32'd20);
    pulse_run();
    chk("start2", {31'd0, bus.eng_start}, 32'd1);
    bus.eng_done = 1'b0;
    tick();
    tick();
    chk("wait_high_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_start",  {31'd0, bus.eng_start},  32'd0);
    chk("mid_rst_busy",   {31'd0, bus.busy},       32'd0);
    chk("mid_rst_hvalid", {31'd0, bus.hash_valid}, 32'd0);
    chk("mid_rst_err",    {31'd0, bus.err},        32'd0);
    bus.eng_done = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("mid_rst_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      chk("ram_kept", dut.u_ram.mem_r[i], 32'h1000_0000 + 32'(i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
